div32_iter: RTL

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU group.
- Sits in the EX stage beside the 32-bit adder/subtracter and issues one trial subtraction per cycle through a step sub-module.
- Holds the pipeline via busy and returns one result word with a one-cycle ready pulse.
- Supports cancel so a flush or interrupt can kill an in-flight divide.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 25 ++
 rtl/div32_iter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative RV32M divider.
package div_pkg;

    localparam int unsigned XLEN = 32;

    // funct3[1:0] of the divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Architected special-case results
    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    // Two's complement negation modulo 2^XLEN
    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return XLEN'(0) - x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    localparam int unsigned XW = WIDTH + 2;

    logic [XW-1:0] shifted;
    logic [XW-1:0] diff;

    // Subtract as add-of-complement; one guard bit above the remainder gives the sign
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted + (~{2'b00, dvs}) + XW'(1);
        q_bit    = ~diff[XW-1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div32_iter.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU with cancel and one-cycle ready pulse.
module div32_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] r
);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             busy_n;
    logic             ready_n;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             is_rem;

    logic             is_signed;
    logic             div_zero;
    logic             ovf;
    logic             special;
    logic [WIDTH-1:0] special_r;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             go;
    logic             step_en;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_f;
    logic [WIDTH-1:0] rem_f;
    logic [WIDTH-1:0] fix_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .bit_in   (quo[WIDTH-1]),
        .dvs      (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Operand decode, special-case detection and final sign fix-up
    always_comb begin
        is_signed = ~op[0];
        div_zero  = (b == '0);
        ovf       = is_signed && (a == INT_MIN) && (b == DIV0_Q);
        special   = div_zero || ovf;
        if (div_zero) special_r = op[1] ? a : DIV0_Q;
        else          special_r = op[1] ? '0 : INT_MIN;
        mag_a     = (is_signed && a[WIDTH-1]) ? neg(a) : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? neg(b) : b;
        go        = (state == S_IDLE) && start && !cancel;
        step_en   = (state == S_RUN) && !cancel && (cnt != '0);
        quo_f     = sign_q ? neg(quo) : quo;
        rem_f     = sign_r ? neg(rem[WIDTH-1:0]) : rem[WIDTH-1:0];
        fix_r     = is_rem ? rem_f : quo_f;
    end

    // Next-state logic; cancel returns to IDLE from any active state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (go) state_n = special ? S_DONE : S_RUN;
            S_RUN: begin
                if (cancel)          state_n = S_IDLE;
                else if (cnt == '0)  state_n = S_FIX;
            end
            S_FIX:  state_n = cancel ? S_IDLE : S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        busy_n  = (state_n != S_IDLE);
        ready_n = (state_n == S_DONE);
    end

    // State and registered status outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            ready <= ready_n;
        end
    end

    // Datapath: operand capture, one restoring step per RUN cycle, result load
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            is_rem <= 1'b0;
            r      <= '0;
        end else begin
            if (go) begin
                quo    <= mag_a;
                dvs    <= mag_b;
                rem    <= '0;
                cnt    <= CNT_W'(WIDTH);
                sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= is_signed & a[WIDTH-1];
                is_rem <= op[1];
                if (special) r <= special_r;
            end else if (step_en) begin
                rem <= step_rem;
                quo <= {quo[WIDTH-2:0], step_q};
                cnt <= cnt - CNT_W'(1);
            end else if ((state == S_FIX) && !cancel) begin
                r <= fix_r;
            end
        end
    end

endmodule
